// File: rtl/badvinstr_gen.sv
// badvinstr_gen: producer side of the CP0 BadVInstr capture path.
// Carries instruction words D->E->M with their exception status and makes the
// abort / interrupt decision at M. Data outputs are registered one cycle after
// the decision, together with a single-cycle strobe and the pipeline flush.
module badvinstr_gen #(
  parameter int unsigned   W        = 32,
  parameter logic [W-1:0]  NOP_WORD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] instr_f,
  input  logic         valid_f,
  input  logic         is_branch_f,
  input  logic         exc_f,
  input  logic         exc_d,
  input  logic         exc_e,
  input  logic         stall,
  input  logic         irq,
  output logic [W-1:0] badvinstr_p,
  output logic [W-1:0] badvinstrp_p,
  output logic         bd,
  output logic         exception_abort,
  output logic         irq_take,
  output logic         flush
);

  logic [W-1:0] d_instr_q, d_instr_d, e_instr_q, e_instr_d, m_instr_q, m_instr_d;
  logic         d_valid_q, d_valid_d, e_valid_q, e_valid_d, m_valid_q, m_valid_d;
  logic         d_br_q, d_br_d, e_br_q, e_br_d, m_br_q, m_br_d;
  logic         d_exc_q, d_exc_d, e_exc_q, e_exc_d, m_exc_q, m_exc_d;
  logic         d_ds_q, d_ds_d, e_ds_q, e_ds_d, m_ds_q, m_ds_d;

  logic         irq_pend_q, irq_pend_d;
  logic [W-1:0] last_br_q, last_br_d;
  logic [W-1:0] bvi_q, bvi_d, bvip_q, bvip_d;
  logic         bd_q, bd_d, abort_q, abort_d, take_q, take_d;

  logic         irq_pend_w, abort_dec, take_dec, commit_ok, flush_w;

  assign flush_w = abort_q | take_q;

  // Commit decision at M; an interrupt arriving this cycle already counts as pending.
  always_comb begin
    irq_pend_w = irq_pend_q | irq;
    abort_dec  = m_valid_q & m_exc_q;
    take_dec   = m_valid_q & ~m_exc_q & irq_pend_w;
    commit_ok  = m_valid_q & ~abort_dec & ~take_dec;
  end

  // Stage next-state: flush wins, then stall/advance; M empties right after a decision.
  always_comb begin
    d_instr_d = d_instr_q; d_valid_d = d_valid_q; d_br_d = d_br_q; d_exc_d = d_exc_q; d_ds_d = d_ds_q;
    e_instr_d = e_instr_q; e_valid_d = e_valid_q; e_br_d = e_br_q; e_exc_d = e_exc_q; e_ds_d = e_ds_q;
    m_instr_d = m_instr_q; m_valid_d = m_valid_q; m_br_d = m_br_q; m_exc_d = m_exc_q; m_ds_d = m_ds_q;
    if (flush_w) begin
      d_instr_d = NOP_WORD; d_valid_d = 1'b0; d_br_d = 1'b0; d_exc_d = 1'b0; d_ds_d = 1'b0;
      e_instr_d = NOP_WORD; e_valid_d = 1'b0; e_br_d = 1'b0; e_exc_d = 1'b0; e_ds_d = 1'b0;
      m_instr_d = NOP_WORD; m_valid_d = 1'b0; m_br_d = 1'b0; m_exc_d = 1'b0; m_ds_d = 1'b0;
    end else begin
      if (!stall) begin
        // A bubble from fetch carries NOP_WORD so stale words never reach the outputs.
        d_instr_d = valid_f ? instr_f : NOP_WORD;
        d_valid_d = valid_f;
        d_br_d    = valid_f & is_branch_f;
        d_exc_d   = valid_f & exc_f;
        d_ds_d    = valid_f & d_valid_q & d_br_q;
        e_instr_d = d_instr_q;
        e_valid_d = d_valid_q;
        e_br_d    = d_br_q;
        e_exc_d   = d_exc_q | exc_d;
        e_ds_d    = d_ds_q;
        m_instr_d = e_instr_q;
        m_valid_d = e_valid_q;
        m_br_d    = e_br_q;
        m_exc_d   = e_exc_q | exc_e;
        m_ds_d    = e_ds_q;
      end
      if (abort_dec || take_dec) begin
        m_instr_d = NOP_WORD; m_valid_d = 1'b0; m_br_d = 1'b0; m_exc_d = 1'b0; m_ds_d = 1'b0;
      end
    end
  end

  // Capture data, strobes, pending interrupt and the last committed branch word.
  always_comb begin
    bvi_d      = bvi_q;
    bvip_d     = bvip_q;
    bd_d       = bd_q;
    abort_d    = abort_dec;
    take_d     = take_dec;
    irq_pend_d = irq | (irq_pend_q & ~take_dec);
    last_br_d  = last_br_q;
    if (abort_dec || take_dec) begin
      bvi_d  = m_instr_q;
      bd_d   = m_ds_q;
      bvip_d = m_ds_q ? last_br_q : NOP_WORD;
    end
    if (commit_ok) begin
      last_br_d = m_br_q ? m_instr_q : NOP_WORD;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_instr_q <= NOP_WORD; d_valid_q <= 1'b0; d_br_q <= 1'b0; d_exc_q <= 1'b0; d_ds_q <= 1'b0;
      e_instr_q <= NOP_WORD; e_valid_q <= 1'b0; e_br_q <= 1'b0; e_exc_q <= 1'b0; e_ds_q <= 1'b0;
      m_instr_q <= NOP_WORD; m_valid_q <= 1'b0; m_br_q <= 1'b0; m_exc_q <= 1'b0; m_ds_q <= 1'b0;
      irq_pend_q <= 1'b0;
      last_br_q  <= NOP_WORD;
      bvi_q      <= NOP_WORD;
      bvip_q     <= NOP_WORD;
      bd_q       <= 1'b0;
      abort_q    <= 1'b0;
      take_q     <= 1'b0;
    end else begin
      d_instr_q <= d_instr_d; d_valid_q <= d_valid_d; d_br_q <= d_br_d; d_exc_q <= d_exc_d; d_ds_q <= d_ds_d;
      e_instr_q <= e_instr_d; e_valid_q <= e_valid_d; e_br_q <= e_br_d; e_exc_q <= e_exc_d; e_ds_q <= e_ds_d;
      m_instr_q <= m_instr_d; m_valid_q <= m_valid_d; m_br_q <= m_br_d; m_exc_q <= m_exc_d; m_ds_q <= m_ds_d;
      irq_pend_q <= irq_pend_d;
      last_br_q  <= last_br_d;
      bvi_q      <= bvi_d;
      bvip_q     <= bvip_d;
      bd_q       <= bd_d;
      abort_q    <= abort_d;
      take_q     <= take_d;
    end
  end

  assign badvinstr_p     = bvi_q;
  assign badvinstrp_p    = bvip_q;
  assign bd              = bd_q;
  assign exception_abort = abort_q;
  assign irq_take        = take_q;
  assign flush           = flush_w;

endmodule
